tlcd_text_scroller: RTL and testbench
=====================================

// Module: tlcd_text_scroller
// PURPOSE
//  Upstream source for tlcd_controller: drives its TEXT_STRING_UPPER/LOWER inputs.
//  Holds a MSG_LEN-char message in a circular byte register and exposes a 16-char
//  window that scrolls one char per step, left or right, wrapping modulo MSG_LEN.
//  A registered UPDATE pulse tells the downstream controller to redraw.
// PARAMETERS
//  MSG_LEN      32                  message length in chars, legal range 16..63
//  MSG          32 spaces           8*MSG_LEN-bit string; char 0 is in the MSBs
//  LOWER_TEXT   16 spaces           128-bit static lower-line string
//  STEP_CYCLES  1000                CLK cycles per scroll step, minimum 2
//  HOLD_STEPS   2                   steps shown at offset 0 before scrolling starts; 0 is legal
// PORTS
//  CLK                input   1    clock
//  RESETN             input   1    asynchronous reset, active-high
//  ENABLE             input   1    1 = scroll; 0 = idle and restore message
//  PAUSE              input   1    1 = freeze step timer and FSM, text held
//  DIR                input   1    0 = scroll left (offset+1), 1 = right (offset-1)
//  TEXT_STRING_UPPER  output  128  window; [127:120] = LCD column 0
//  TEXT_STRING_LOWER  output  128  constant LOWER_TEXT
//  OFFSET             output  6    index of the message char shown in column 0
//  UPDATE             output  1    1-cycle pulse, coincides with new window text
// BEHAVIOUR
//  Reset (async, RESETN=1):
//   - msg_q=MSG, OFFSET=0, UPDATE=0, state=IDLE, cnt=0, hold_cnt=0.
//   - TEXT_STRING_UPPER=MSG[8*MSG_LEN-1 -: 128].
//  Output timing: TEXT_STRING_UPPER = msg_q[8*MSG_LEN-1 -: 128], taken straight from the register.
//  Step timer:
//   - cnt counts 0..STEP_CYCLES-1 in HOLD/RUN while PAUSE=0; tick = (cnt==STEP_CYCLES-1).
//   - On the tick edge, cnt returns to 0.
//  FSM (all transitions at a CLK edge):
//   IDLE:
//    - ENABLE=1 -> HOLD with cnt=0, hold_cnt=0.
//    - If HOLD_STEPS==0, go directly to RUN.
//   HOLD:
//    - On tick: hold_cnt++; when hold_cnt==HOLD_STEPS-1 -> RUN.
//    - No rotation in HOLD.
//   RUN:
//    - On tick, DIR is sampled.
//    - DIR=0: msg_q rotates left by 8 bits, OFFSET=(OFFSET+1)%MSG_LEN.
//    - DIR=1: msg_q rotates right by 8 bits, OFFSET=(OFFSET==0)?MSG_LEN-1:OFFSET-1.
//    - UPDATE=1 for that single cycle.
//   HOLD or RUN with ENABLE=0:
//    - Next edge -> IDLE, msg_q=MSG, OFFSET=0, cnt=0.
//    - UPDATE=1 for one cycle only if OFFSET was nonzero.
//  PAUSE=1: cnt, hold_cnt, state and msg_q frozen; UPDATE=0. ENABLE=0 overrides PAUSE.
//  UPDATE invariant: UPDATE is high in exactly the cycles where TEXT_STRING_UPPER
//   differs from its value in the previous cycle.
//  MSG_LEN==16: rotation wraps the whole window; the invariant still holds.
//  Reset mid-scroll: everything returns to the reset values immediately. No partial window persists.
// STRUCTURE
//  Shared include tlcd_defs.vh:
//   - CHAR_W=8, LCD_COLS=16, LINE_W=128.
//   - FSM codes ST_IDLE/ST_HOLD/ST_RUN (2 bits).
//  One sub-module, tlcd_step_timer:
//   - Parameter STEP_CYCLES; inputs CLK, RESETN, run, clr; output tick.
//   - Also reused for the controller's delays.
//  Top-level: FSM, hold counter, rotation register, OFFSET arithmetic, UPDATE register.
// TESTING (MSG_LEN=20, MSG="ABCDEFGHIJKLMNOPQRST", STEP_CYCLES=4, HOLD_STEPS=2)
//  1 Reset, ENABLE=0 -> upper="ABCDEFGHIJKLMNOP", OFFSET=0, UPDATE=0. Text stays static for 100 cycles.
//  2 ENABLE=1 sampled at edge E, DIR=0 -> no change until E+12.
//    At E+12: upper="BCDEFGHIJKLMNOPQ", OFFSET=1, UPDATE high 1 cycle; next change at E+16.
//  3 Continue 20 steps left -> OFFSET sequence 1..19,0; after step 17 upper="RSTABCDEFGHIJKLM".
//    After step 20 the text is back to the reset text.
//  4 From reset, DIR=1 -> first step upper="TABCDEFGHIJKLMNO", OFFSET=19.
//    DIR toggled mid-step takes effect only at the next tick.
//  5 PAUSE=1 for 10 cycles mid-run -> no UPDATE, text frozen; the step resumes with the cnt value it had.
//    ENABLE=0 while OFFSET=5 -> next edge reset text, OFFSET=0, one UPDATE.
//  6 RESETN pulse mid-step, asynchronous to CLK -> outputs take reset values before the next edge.
//    After release, the block behaves exactly as in scenario 2.

Source files
------------

// File: rtl/tlcd_text_scroller_pkg.sv
// Shared constants and FSM encoding for the text LCD scroller and its step timer.
package tlcd_text_scroller_pkg;

    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned LCD_COLS = 16;
    localparam int unsigned LINE_W   = CHAR_W * LCD_COLS;
    localparam int unsigned OFF_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/tlcd_text_scroller_step_timer.sv
// Free-running step divider: tick marks the last cycle of each STEP_CYCLES period.
module tlcd_step_timer #(
    parameter int unsigned STEP_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over run so an exit to idle always restarts the period.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = run && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tlcd_text_scroller.sv
// Circular message register exposing a 16-char scrolling window for tlcd_controller.
module tlcd_text_scroller
    import tlcd_text_scroller_pkg::*;
#(
    parameter int unsigned MSG_LEN     = 32,
    parameter logic [8*MSG_LEN-1:0] MSG = {MSG_LEN{8'h20}},
    parameter logic [127:0] LOWER_TEXT = {16{8'h20}},
    parameter int unsigned STEP_CYCLES = 1000,
    parameter int unsigned HOLD_STEPS  = 2
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         ENABLE,
    input  logic         PAUSE,
    input  logic         DIR,
    output logic [127:0] TEXT_STRING_UPPER,
    output logic [127:0] TEXT_STRING_LOWER,
    output logic [5:0]   OFFSET,
    output logic         UPDATE
);

    localparam int unsigned MSG_W  = CHAR_W * MSG_LEN;
    localparam int unsigned HOLD_W = (HOLD_STEPS < 2) ? 1 : $clog2(HOLD_STEPS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS == 0) ? 0 : HOLD_STEPS - 1);
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(MSG_LEN - 1);

    scroll_state_t     state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic              update_q, update_d;
    logic              tick;

    tlcd_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .CLK    (CLK),
        .RESETN (RESETN),
        .run    (!PAUSE),
        .clr    ((state_q == ST_IDLE) || !ENABLE),
        .tick   (tick)
    );

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            msg_q      <= MSG;
            offset_q   <= '0;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            msg_q      <= msg_d;
            offset_q   <= offset_d;
            update_q   <= update_d;
        end
    end

    // ENABLE=0 restores the message from any active state, even while paused.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        msg_d      = msg_q;
        offset_d   = offset_q;
        update_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ENABLE && !PAUSE) begin
                    hold_cnt_d = '0;
                    state_d    = (HOLD_STEPS == 0) ? ST_RUN : ST_HOLD;
                end
            end
            ST_HOLD, ST_RUN: begin
                if (!ENABLE) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    msg_d      = MSG;
                    offset_d   = '0;
                    update_d   = (offset_q != '0);
                end else if (tick && (state_q == ST_HOLD)) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (tick) begin
                    update_d = 1'b1;
                    if (DIR) begin
                        msg_d    = {msg_q[CHAR_W-1:0], msg_q[MSG_W-1:CHAR_W]};
                        offset_d = (offset_q == '0) ? OFF_LAST : offset_q - OFF_W'(1);
                    end else begin
                        msg_d    = {msg_q[MSG_W-CHAR_W-1:0], msg_q[MSG_W-1 -: CHAR_W]};
                        offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign TEXT_STRING_UPPER = msg_q[MSG_W-1 -: LINE_W];
    assign TEXT_STRING_LOWER = LOWER_TEXT;
    assign OFFSET            = offset_q;
    assign UPDATE            = update_q;

endmodule

// File: tb/tb_tlcd_text_scroller.sv
// Bench for tlcd_text_scroller: directed table, corner sequences and random run vs. a step-count model.
module tb_tlcd_text_scroller;

    localparam int unsigned L    = 20;
    localparam int unsigned STEP = 4;
    localparam int unsigned HOLD = 2;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b1;
    logic         ENABLE = 1'b0;
    logic         PAUSE = 1'b0;
    logic         DIR = 1'b0;
    logic [127:0] TEXT_STRING_UPPER;
    logic [127:0] TEXT_STRING_LOWER;
    logic [5:0]   OFFSET;
    logic         UPDATE;

    tlcd_text_scroller #(
        .MSG_LEN     (L),
        .MSG         ("ABCDEFGHIJKLMNOPQRST"),
        .LOWER_TEXT  ("lower line text!"),
        .STEP_CYCLES (STEP),
        .HOLD_STEPS  (HOLD)
    ) dut (
        .CLK               (CLK),
        .RESETN            (RESETN),
        .ENABLE            (ENABLE),
        .PAUSE             (PAUSE),
        .DIR               (DIR),
        .TEXT_STRING_UPPER (TEXT_STRING_UPPER),
        .TEXT_STRING_LOWER (TEXT_STRING_LOWER),
        .OFFSET            (OFFSET),
        .UPDATE            (UPDATE)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    byte msg_b [L];
    int  m_active, m_cyc, m_steps, m_off;
    logic [127:0] m_prev;

    typedef struct {
        bit en;
        bit pause;
        bit dir;
        int cycles;
        int exp_off;
        bit exp_upd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] window(input int off);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127-8*i -: 8] = msg_b[(off + i) % L];
        return w;
    endfunction

    task automatic model_reset();
        m_active = 0; m_cyc = 0; m_steps = 0; m_off = 0;
        m_prev = window(0);
    endtask

    // Model: count whole steps since enable; steps beyond the hold count move the window.
    task automatic model_edge();
        if (RESETN) begin
            model_reset();
        end else if (m_active == 0) begin
            if (ENABLE && !PAUSE) begin
                m_active = 1; m_cyc = 0; m_steps = 0;
            end
        end else if (!ENABLE) begin
            m_active = 0; m_cyc = 0; m_off = 0;
        end else if (!PAUSE) begin
            if (m_cyc == STEP - 1) begin
                m_cyc = 0;
                m_steps++;
                if (m_steps > HOLD) m_off = DIR ? (m_off + L - 1) % L : (m_off + 1) % L;
            end else begin
                m_cyc++;
            end
        end
    endtask

    task automatic step();
        logic [127:0] exp_text;
        @(posedge CLK);
        model_edge();
        #1;
        exp_text = window(m_off);
        chk("model_text", TEXT_STRING_UPPER, exp_text);
        chk("model_offset", 128'(OFFSET), 128'(m_off));
        chk("model_update", 128'(UPDATE), 128'(exp_text != m_prev));
        m_prev = exp_text;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Enable edge is the first step; the window must move on the 13th.
    task automatic first_step_check(input logic [127:0] exp_text, input int exp_off);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("hold_no_update", 128'(UPDATE), 128'(0));
        end
        step();
        chk("first_step_text", TEXT_STRING_UPPER, exp_text);
        chk("first_step_offset", 128'(OFFSET), 128'(exp_off));
        chk("first_step_update", 128'(UPDATE), 128'(1));
    endtask

    initial begin
        string s;
        s = "ABCDEFGHIJKLMNOPQRST";
        for (int i = 0; i < L; i++) msg_b[i] = s[i];

        vecs[0] = '{1, 0, 0, 13, 1, 1};
        vecs[1] = '{1, 0, 0, 8, 3, 1};
        vecs[2] = '{1, 1, 0, 9, 3, 0};
        vecs[3] = '{1, 0, 1, 4, 2, 1};
        vecs[4] = '{1, 0, 1, 12, 19, 1};
        vecs[5] = '{0, 0, 0, 1, 0, 1};
        vecs[6] = '{0, 0, 0, 5, 0, 0};
        vecs[7] = '{1, 1, 0, 13, 0, 0};
        vecs[8] = '{1, 0, 0, 13, 1, 1};
        vecs[9] = '{0, 0, 0, 1, 0, 1};

        // Reset state and a long static idle stretch.
        model_reset();
        repeat (3) @(posedge CLK);
        #2;
        chk("reset_text", TEXT_STRING_UPPER, "ABCDEFGHIJKLMNOP");
        chk("reset_offset", 128'(OFFSET), 128'(0));
        chk("reset_update", 128'(UPDATE), 128'(0));
        chk("lower_text", TEXT_STRING_LOWER, "lower line text!");
        RESETN = 1'b0;
        run(100);
        chk("idle_static_text", TEXT_STRING_UPPER, "ABCDEFGHIJKLMNOP");

        // Left scroll through a full wrap.
        ENABLE = 1'b1; DIR = 1'b0;
        first_step_check("BCDEFGHIJKLMNOPQ", 1);
        for (int s2 = 2; s2 <= 20; s2++) begin
            run(STEP);
            chk("left_offset_seq", 128'(OFFSET), 128'(s2 % L));
            chk("left_step_update", 128'(UPDATE), 128'(1));
            if (s2 == 17) chk("step17_text", TEXT_STRING_UPPER, "RSTABCDEFGHIJKLM");
        end
        chk("wrap_text", TEXT_STRING_UPPER, "ABCDEFGHIJKLMNOP");

        // Pause mid-step resumes with the same count.
        run(2);
        PAUSE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_no_update", 128'(UPDATE), 128'(0));
        end
        PAUSE = 1'b0;
        step();
        chk("resume_no_early_step", 128'(UPDATE), 128'(0));
        step();
        chk("resume_step_update", 128'(UPDATE), 128'(1));
        chk("resume_step_offset", 128'(OFFSET), 128'(1));
        run(16);
        chk("before_disable_offset", 128'(OFFSET), 128'(5));
        ENABLE = 1'b0;
        step();
        chk("disable_text", TEXT_STRING_UPPER, "ABCDEFGHIJKLMNOP");
        chk("disable_offset", 128'(OFFSET), 128'(0));
        chk("disable_update", 128'(UPDATE), 128'(1));
        step();
        chk("disable_update_one_cycle", 128'(UPDATE), 128'(0));

        // Right scroll; DIR change mid-step only counts at the tick.
        ENABLE = 1'b1; DIR = 1'b1;
        first_step_check("TABCDEFGHIJKLMNO", 19);
        run(1);
        DIR = 1'b0;
        run(2);
        chk("dir_change_no_step", 128'(OFFSET), 128'(19));
        step();
        chk("dir_change_offset", 128'(OFFSET), 128'(0));

        // Asynchronous reset mid-step, then a clean restart.
        run(5);
        #2;
        RESETN = 1'b1;
        model_reset();
        #1;
        chk("async_reset_text", TEXT_STRING_UPPER, "ABCDEFGHIJKLMNOP");
        chk("async_reset_offset", 128'(OFFSET), 128'(0));
        chk("async_reset_update", 128'(UPDATE), 128'(0));
        run(2);
        RESETN = 1'b0;
        ENABLE = 1'b1; DIR = 1'b0;
        first_step_check("BCDEFGHIJKLMNOPQ", 1);

        // Directed table from idle.
        ENABLE = 1'b0;
        run(1);
        for (int v = 0; v < 10; v++) begin
            ENABLE = vecs[v].en; PAUSE = vecs[v].pause; DIR = vecs[v].dir;
            run(vecs[v].cycles);
            chk("table_offset", 128'(OFFSET), 128'(vecs[v].exp_off));
            chk("table_update", 128'(UPDATE), 128'(vecs[v].exp_upd));
        end
        PAUSE = 1'b0;

        // Randomised run against the model, with occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            ENABLE = ($urandom_range(0, 99) < 97);
            PAUSE  = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 9) == 0) DIR = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                #2;
                RESETN = 1'b1;
                model_reset();
                #1;
                chk("rand_async_reset_offset", 128'(OFFSET), 128'(0));
                step();
                RESETN = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
